// File: rtl/chaser_monitor.sv
// Monitors an 8-bit LED chaser pattern: tracks the lit position and rotation direction,
// locks onto a steady chase, and counts steps and faults once locked.
module chaser_monitor #(
  parameter int unsigned LOCK_STEPS = 4,
  parameter int unsigned HOLD_MAX   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  leds,
  output logic        onehot,
  output logic [2:0]  pos,
  output logic        dir,
  output logic        locked,
  output logic [15:0] step_count,
  output logic        err,
  output logic [7:0]  err_count
);

  localparam int unsigned RUN_W  = $clog2(LOCK_STEPS + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, ERROR} state_t;

  state_t            state, state_nx;
  logic [7:0]        prev, prev_nx;
  logic [RUN_W-1:0]  run, run_nx, run_inc;
  logic [HOLD_W-1:0] hold_cnt, hold_nx, hold_inc;

  logic        onehot_nx, dir_nx, locked_nx, err_nx;
  logic [2:0]  pos_nx, sample_idx;
  logic [15:0] step_count_nx;
  logic [7:0]  err_count_nx;

  logic sample_oh, prev_oh, changed, left, right, step_fwd, hold_hit;

  always_comb begin
    sample_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (leds[i]) sample_idx = 3'(i);
    end
  end

  always_comb begin
    sample_oh = (leds != '0) && ((leds & (leds - 8'd1)) == '0);
    prev_oh   = (prev != '0) && ((prev & (prev - 8'd1)) == '0);
    changed   = (leds != prev);
    left      = sample_oh && prev_oh && (leds == {prev[6:0], prev[7]});
    right     = sample_oh && prev_oh && (leds == {prev[0], prev[7:1]});
    step_fwd  = dir ? right : left;
    hold_inc  = (hold_cnt == HOLD_W'(HOLD_MAX)) ? hold_cnt : hold_cnt + 1'b1;
    hold_hit  = !changed && (hold_inc == HOLD_W'(HOLD_MAX));
    run_inc   = run + 1'b1;
  end

  always_comb begin
    state_nx      = state;
    prev_nx       = prev;
    run_nx        = run;
    hold_nx       = hold_cnt;
    onehot_nx     = onehot;
    pos_nx        = pos;
    dir_nx        = dir;
    step_count_nx = step_count;
    err_count_nx  = err_count;
    err_nx        = 1'b0;

    if (enable) begin
      prev_nx   = leds;
      hold_nx   = changed ? '0 : hold_inc;
      onehot_nx = sample_oh;
      if (sample_oh) pos_nx = sample_idx;

      unique case (state)
        IDLE, ERROR: begin
          if (sample_oh) begin
            state_nx = ACQUIRE;
            run_nx   = '0;
          end
        end
        ACQUIRE: begin
          if (!sample_oh) begin
            state_nx = IDLE;
          end else if (left || right) begin
            // The first step of a run picks the direction; later steps must agree or restart at 1.
            if (run == '0 || step_fwd) begin
              run_nx = run_inc;
              dir_nx = right;
              if (run_inc == RUN_W'(LOCK_STEPS)) state_nx = LOCKED;
            end else begin
              run_nx = RUN_W'(1);
              dir_nx = ~dir;
            end
          end else if (changed) begin
            run_nx = '0;
          end
        end
        LOCKED: begin
          if (step_fwd) begin
            step_count_nx = step_count + 16'd1;
          end else if (changed || !sample_oh || hold_hit) begin
            state_nx = ERROR;
            err_nx   = 1'b1;
            if (err_count != 8'hFF) err_count_nx = err_count + 8'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    locked_nx = (state_nx == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      run        <= '0;
      hold_cnt   <= '0;
      onehot     <= 1'b0;
      pos        <= '0;
      dir        <= 1'b0;
      locked     <= 1'b0;
      step_count <= '0;
      err        <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_nx;
      prev       <= prev_nx;
      run        <= run_nx;
      hold_cnt   <= hold_nx;
      onehot     <= onehot_nx;
      pos        <= pos_nx;
      dir        <= dir_nx;
      locked     <= locked_nx;
      step_count <= step_count_nx;
      err        <= err_nx;
      err_count  <= err_count_nx;
    end
  end

endmodule

// File: tb/tb_chaser_monitor.sv
// Self-checking bench for chaser_monitor: directed scenarios plus randomized traffic,
// every cycle compared against a position/direction-level reference model.
module tb_chaser_monitor;

  localparam int unsigned LOCK = 4;
  localparam int unsigned HOLD = 16;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [7:0]  leds;
  logic        onehot, dir, locked, err;
  logic [2:0]  pos;
  logic [15:0] step_count;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;

  chaser_monitor #(.LOCK_STEPS(LOCK), .HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .leds(leds),
    .onehot(onehot), .pos(pos), .dir(dir), .locked(locked),
    .step_count(step_count), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  string      m_mode;
  logic [7:0] m_prev;
  int         m_run, m_hold, m_pos, m_steps, m_errs;
  bit         m_oh, m_dir, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ones(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [7:0] bit_at(input int i);
    logic [7:0] b;
    b = 8'd1 << (i % 8);
    return b;
  endfunction

  task automatic model_reset();
    m_mode = "IDLE"; m_prev = '0; m_run = 0; m_hold = 0; m_pos = 0;
    m_steps = 0; m_errs = 0; m_oh = 0; m_dir = 0; m_err = 0;
  endtask

  task automatic model(input bit r, input bit e, input logic [7:0] l);
    bit oh, chg, lft, rgt, fwd;
    int nh;
    m_err = 0;
    if (r) begin
      model_reset();
      return;
    end
    if (!e) return;
    oh  = (ones(l) == 1);
    chg = (l != m_prev);
    lft = oh && ones(m_prev) == 1 && idx(l) == (idx(m_prev) + 1) % 8;
    rgt = oh && ones(m_prev) == 1 && idx(l) == (idx(m_prev) + 7) % 8;
    fwd = m_dir ? rgt : lft;
    nh  = chg ? 0 : ((m_hold + 1 > HOLD) ? HOLD : m_hold + 1);
    if (m_mode == "IDLE" || m_mode == "ERROR") begin
      if (oh) begin m_mode = "ACQUIRE"; m_run = 0; end
    end else if (m_mode == "ACQUIRE") begin
      if (!oh) m_mode = "IDLE";
      else if (lft || rgt) begin
        if (m_run == 0 || fwd) begin
          m_run++; m_dir = rgt;
          if (m_run >= LOCK) m_mode = "LOCKED";
        end else begin
          m_run = 1; m_dir = rgt;
        end
      end else if (chg) m_run = 0;
    end else begin
      if (fwd) m_steps = (m_steps + 1) % 65536;
      else if (chg || !oh || nh == HOLD) begin
        m_mode = "ERROR"; m_err = 1;
        if (m_errs < 255) m_errs++;
      end
    end
    m_prev = l; m_hold = nh; m_oh = oh;
    if (oh) m_pos = idx(l);
  endtask

  task automatic compare_all();
    check("onehot", onehot, m_oh);
    check("pos", pos, m_pos);
    check("dir", dir, m_dir);
    check("locked", locked, m_mode == "LOCKED");
    check("step_count", step_count, m_steps);
    check("err", err, m_err);
    check("err_count", err_count, m_errs);
  endtask

  task automatic cycle(input bit r, input bit e, input logic [7:0] l);
    rst = r; enable = e; leds = l;
    @(posedge clk);
    model(r, e, l);
    #1;
    compare_all();
  endtask

  // Feed LOCK+1 consecutive positions starting at index s, rotating left (d=0) or right (d=1).
  task automatic acquire(input int s, input bit d);
    for (int k = 0; k <= int'(LOCK); k++) cycle(0, 1, bit_at(d ? s + 8 * 8 - k : s + k));
  endtask

  logic [7:0]  cur;
  logic [7:0]  snap_pos;
  logic [15:0] snap_steps;

  initial begin
    model_reset();
    rst = 1; enable = 0; leds = '0;
    cycle(1, 1, 8'hFF);
    cycle(1, 0, 8'h00);
    check("rst_locked", locked, 0);
    check("rst_err_count", err_count, 0);

    // Lock onto a left chase, then step through the wrap
    acquire(0, 0);
    check("lockL_locked", locked, 1);
    cycle(0, 1, 8'h20); cycle(0, 1, 8'h40); cycle(0, 1, 8'h80); cycle(0, 1, 8'h01);
    check("lockL_steps", step_count, 4);
    check("lockL_pos", pos, 0);
    check("lockL_dir", dir, 0);
    check("lockL_err", err, 0);

    // Right chase with 0->7 wrap
    cycle(1, 0, 8'h00);
    cycle(0, 1, 8'h01); cycle(0, 1, 8'h80); cycle(0, 1, 8'h40);
    cycle(0, 1, 8'h20); cycle(0, 1, 8'h10);
    check("lockR_dir", dir, 1);
    check("lockR_locked", locked, 1);
    cycle(0, 1, 8'h08);
    check("lockR_steps", step_count, 1);
    check("lockR_pos", pos, 3);

    // Long pause while locked must not count as a stall
    snap_pos = {5'd0, pos}; snap_steps = step_count;
    for (int k = 0; k < 50; k++) cycle(0, 0, 8'h08);
    check("pause_locked", locked, 1);
    check("pause_err_count", err_count, 0);
    check("pause_pos", pos, snap_pos);
    check("pause_steps", step_count, snap_steps);
    cycle(0, 1, 8'h04); cycle(0, 1, 8'h02);
    check("pause_resume_steps", step_count, 3);

    // Faults while locked: jump, non-one-hot, stall
    cycle(1, 0, 8'h00);
    acquire(5, 0);
    cycle(0, 1, 8'h10);
    check("jump_err", err, 1);
    check("jump_err_count", err_count, 1);
    check("jump_locked", locked, 0);
    acquire(5, 0);
    cycle(0, 1, 8'h03);
    check("multi_err_count", err_count, 2);
    acquire(0, 0);
    for (int k = 0; k < int'(HOLD) - 1; k++) cycle(0, 1, 8'h10);
    check("hold_no_err_yet", err, 0);
    cycle(0, 1, 8'h10);
    check("hold_err", err, 1);
    check("hold_err_count", err_count, 3);
    cycle(0, 1, 8'h10);
    check("error_no_repulse", err, 0);

    // err_count saturation
    cycle(1, 0, 8'h00);
    for (int k = 0; k < 256; k++) begin
      acquire(0, 0);
      cycle(0, 1, 8'h80);
    end
    check("err_sat", err_count, 255);

    // Reset mid-lock with enable high
    acquire(0, 0);
    cycle(0, 1, 8'h20);
    check("midrst_pre_steps", step_count, 1);
    cycle(1, 1, 8'h40);
    check("midrst_locked", locked, 0);
    check("midrst_steps", step_count, 0);
    check("midrst_err", err, 0);
    check("midrst_err_count", err_count, 0);

    // step_count wrap
    acquire(0, 0);
    for (int k = 0; k < 65535; k++) cycle(0, 1, bit_at(5 + k));
    check("steps_max", step_count, 16'hFFFF);
    cycle(0, 1, bit_at(5 + 65535));
    check("steps_wrap", step_count, 0);

    // Randomized traffic against the model
    cur = leds;
    for (int k = 0; k < 3000; k++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3: cur = ((cur << 1) | (cur >> 7));
        4, 5:       cur = ((cur >> 1) | (cur << 7));
        6, 7:       cur = cur;
        8:          cur = bit_at(int'($urandom_range(0, 7)));
        default:    cur = 8'($urandom);
      endcase
      if (cur == 8'h00 && sel < 8) cur = 8'h01;
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 9) != 0, cur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chaser_monitor.md
CHASER_MONITOR -- requirements
Module: chaser_monitor

Interface
REQ-001 SHALL have parameter LOCK_STEPS, default 4: consecutive same-direction valid steps needed to reach lock.
REQ-002 SHALL have parameter HOLD_MAX, default 16: maximum consecutive enabled cycles with an unchanged pattern while locked.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port enable, input, 1 bit: sample qualifier; when low, all state freezes.
REQ-006 SHALL have port leds, input, 8 bits: observed chaser pattern.
REQ-007 SHALL have port onehot, output, 1 bit: last enabled sample had exactly one bit set.
REQ-008 SHALL have port pos, output, 3 bits: index of the set bit in the last one-hot enabled sample.
REQ-009 SHALL have port dir, output, 1 bit: 0 = rotate-left (index +1, 7->0 wrap); 1 = rotate-right (index -1, 0->7 wrap).
REQ-010 SHALL have port locked, output, 1 bit: high only in state LOCKED.
REQ-011 SHALL have port step_count, output, 16 bits: valid steps counted while LOCKED.
REQ-012 SHALL have port err, output, 1 bit: one-cycle error pulse.
REQ-013 SHALL have port err_count, output, 8 bits: error total.

Function
REQ-014 SHALL register a sample only on cycles with enable=1; prev holds the previous enabled sample.
REQ-015 SHALL define a step as leds!=prev with both leds and prev one-hot.
- left step: leds == rotl(prev,1); right step: leds == rotr(prev,1); any other change is a jump.
REQ-016 SHALL drive all outputs from registers, updated on the clock edge that samples the input (1-cycle latency).
REQ-017 SHALL keep hold_cnt: +1 per enabled cycle with leds==prev; cleared on any change; saturates at HOLD_MAX.
REQ-018 SHALL implement states IDLE, ACQUIRE, LOCKED, ERROR.
REQ-019 IDLE: a one-hot enabled sample -> ACQUIRE with run=0; otherwise stay in IDLE.
REQ-020 ACQUIRE: a step in dir, or the first step when run=0 -> run+1, dir set; run reaching LOCK_STEPS -> LOCKED.
REQ-021 ACQUIRE: an opposite-direction step -> run=1, dir flipped; a jump -> run=0; a non-one-hot sample -> IDLE; no err in ACQUIRE.
REQ-022 LOCKED: a step in dir -> pos updated, step_count+1, wrapping 0xFFFF->0x0000.
REQ-023 LOCKED: reverse step, jump, non-one-hot sample, or hold_cnt reaching HOLD_MAX -> err=1 for one cycle, err_count+1, state ERROR.
REQ-024 SHALL saturate err_count at 255.
REQ-025 ERROR: a one-hot enabled sample -> ACQUIRE with run=0; otherwise stay in ERROR, with no further err pulses.
REQ-026 SHALL hold state, prev, hold_cnt, counters and outputs while enable=0; err SHALL be 0 on such cycles and pauses SHALL NOT count as a stall.
REQ-027 SHALL retain step_count across loss of lock; it is cleared only by rst.

Reset
REQ-028 rst=1 SHALL override enable and all inputs.
REQ-029 rst=1 SHALL force state IDLE, prev=0, run=0, hold_cnt=0, onehot=0, pos=0, dir=0, locked=0, step_count=0, err=0, err_count=0.
REQ-030 rst asserted mid-operation SHALL take effect on the next edge with no err pulse, and the first enabled sample after release SHALL be treated as being in IDLE.

Verification
REQ-031 Lock-left: after reset, feed 01,02,04,08,10 (hex), one per enabled cycle -> locked=1 one cycle after 10; further 20,40,80,01 -> step_count=4, pos=0, dir=0, err=0.
REQ-032 Right/wrap: feed 01,80,40,20,10 -> dir=1, locked=1; then 08 -> step_count=1, pos=3.
REQ-033 Pause: while locked, drop enable for 50 cycles with leds constant -> no err, all outputs unchanged; re-enable and continue stepping -> step_count keeps incrementing.
REQ-034 Faults while locked:
- jump 02->10 -> err pulse, err_count=1, locked=0;
- re-acquire, then 0x03 -> err_count=2;
- re-acquire, then hold leds 16 enabled cycles -> err_count=3.
REQ-035 Saturation: force 256 errors -> err_count=255; step_count at 0xFFFF plus one step -> 0x0000.
REQ-036 Reset mid-lock with enable=1 -> next cycle locked=0, step_count=0, err=0, err_count=0.
